// File: rtl/multiplier_seq_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package multiplier_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIXUP,
        DONE
    } mulState_t;

    // Bit count for a down-counter that must hold values 0..b.
    function automatic int unsigned cnt_width(input int unsigned b);
        return (b < 1) ? 1 : $clog2(b + 1);
    endfunction

endpackage

// File: rtl/multiplier_seq_if.sv
// Operand/product handshake bundle for multiplier_seq.
interface multiplier_seq_if #(
    parameter int unsigned A = 16,
    parameter int unsigned B = 8
);
    logic             inValid;
    logic             inReady;
    logic [A-1:0]     a;
    logic [B-1:0]     b;
    logic             outValid;
    logic             outReady;
    logic [A+B-1:0]   out;

    modport master (
        output inValid, a, b, outReady,
        input  inReady, outValid, out
    );

    modport slave (
        input  inValid, a, b, outReady,
        output inReady, outValid, out
    );
endinterface

// File: rtl/multiplier_seq_negate.sv
// Two's-complement conditional negation; shared by multiplier and divider paths.
module conditional_negate #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] in_i,
    input  logic         neg_i,
    output logic [W-1:0] out_o
);
    assign out_o = neg_i ? (W'(0) - in_i) : in_i;
endmodule

// File: rtl/multiplier_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, full-precision
// product, optional sign handling via magnitude multiply plus final negation.
module multiplier_seq
    import multiplier_seq_pkg::*;
#(
    parameter int unsigned A      = 16,
    parameter int unsigned B      = 8,
    parameter bit          SIGNED = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    multiplier_seq_if.slave bus
);
    localparam int unsigned W  = A + B;
    localparam int unsigned CW = cnt_width(B);

    mulState_t      state_q, state_d;
    logic [A-1:0]   mcand_q, mcand_d;
    logic [B-1:0]   mplier_q, mplier_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   out_q, out_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;

    logic [A-1:0]   a_abs;
    logic [B-1:0]   b_abs;
    logic [W-1:0]   acc_fix;
    logic [A-1:0]   addend;
    logic [A:0]     sum;
    logic [W:0]     shifted;
    logic [W-1:0]   acc_next;
    logic           a_neg, b_neg;

    assign a_neg = SIGNED && bus.a[A-1];
    assign b_neg = SIGNED && bus.b[B-1];

    // Most-negative operands negate to themselves and read correctly as unsigned.
    conditional_negate #(.W(A)) u_abs_a (.in_i(bus.a), .neg_i(a_neg), .out_o(a_abs));
    conditional_negate #(.W(B)) u_abs_b (.in_i(bus.b), .neg_i(b_neg), .out_o(b_abs));
    conditional_negate #(.W(W)) u_fix   (.in_i(acc_q), .neg_i(neg_q), .out_o(acc_fix));

    always_comb begin
        addend   = mplier_q[0] ? mcand_q : '0;
        sum      = {1'b0, acc_q[W-1:B]} + {1'b0, addend};
        shifted  = {sum, acc_q[B-1:0]};
        acc_next = shifted[W:1];
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            IDLE: begin
                if (bus.inValid && in_ready_q) begin
                    mcand_d    = a_abs;
                    mplier_d   = b_abs;
                    neg_d      = a_neg ^ b_neg;
                    acc_d      = '0;
                    cnt_d      = CW'(B - 1);
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_next;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '0) begin
                    if (SIGNED) begin
                        state_d = FIXUP;
                    end else begin
                        out_d       = acc_next;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIXUP: begin
                out_d       = acc_fix;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_valid_q && bus.outReady) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.inReady  = in_ready_q;
    assign bus.outValid = out_valid_q;
    assign bus.out      = out_q;

endmodule

// File: tb/tb_multiplier_seq.sv
// Scoreboard bench for multiplier_seq: unsigned and signed instances side by side.
module tb_multiplier_seq;
    localparam int A = 16;
    localparam int B = 8;
    localparam int W = A + B;
    localparam int SOAK_OPS = 2000;

    typedef struct {
        logic [W-1:0] prod;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   rnd_rdy = 1'b0;
    exp_t q_u[$];
    exp_t q_s[$];

    multiplier_seq_if #(.A(A), .B(B)) iu_if ();
    multiplier_seq_if #(.A(A), .B(B)) is_if ();

    multiplier_seq #(.A(A), .B(B), .SIGNED(1'b0)) u_dut_u (
        .clk_i(clk), .rst_i(rst), .bus(iu_if)
    );
    multiplier_seq #(.A(A), .B(B), .SIGNED(1'b1)) u_dut_s (
        .clk_i(clk), .rst_i(rst), .bus(is_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rnd_rdy) begin
            iu_if.outReady = ($urandom_range(0, 3) != 0);
            is_if.outReady = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [W-1:0] ref_prod(input bit s, input logic [A-1:0] av, input logic [B-1:0] bv);
        longint      p;
        logic [63:0] pv;
        if (s) p = longint'($signed(av)) * longint'($signed(bv));
        else   p = longint'(av) * longint'(bv);
        pv = p;
        return pv[W-1:0];
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_in(input bit s, input logic v, input logic [A-1:0] av, input logic [B-1:0] bv);
        if (s) begin is_if.inValid = v; is_if.a = av; is_if.b = bv; end
        else   begin iu_if.inValid = v; iu_if.a = av; iu_if.b = bv; end
    endtask

    function automatic logic in_ready(input bit s);
        return s ? is_if.inReady : iu_if.inReady;
    endfunction

    function automatic logic out_valid(input bit s);
        return s ? is_if.outValid : iu_if.outValid;
    endfunction

    function automatic int qsize(input bit s);
        return s ? q_s.size() : q_u.size();
    endfunction

    task automatic send_x(input bit s, input logic [A-1:0] av, input logic [B-1:0] bv, input logic [W-1:0] exp);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        drive_in(s, 1'b1, av, bv);
        while (!in_ready(s) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("accept_timeout", 64'(n), 64'(0));
            drive_in(s, 1'b0, av, bv);
            return;
        end
        e.prod = exp;
        e.acc  = cyc + 1;
        if (s) q_s.push_back(e); else q_u.push_back(e);
        @(negedge clk);
        drive_in(s, 1'b0, A'($urandom), B'($urandom));
    endtask

    task automatic send(input bit s, input logic [A-1:0] av, input logic [B-1:0] bv);
        send_x(s, av, bv, ref_prod(s, av, bv));
    endtask

    task automatic wait_idle(input bit s);
        int n = 0;
        while ((qsize(s) != 0 || out_valid(s)) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("idle_timeout", 64'(n), 64'(0));
    endtask

    task automatic monitor(input bit s);
        bit           seen = 1'b0;
        exp_t         cur;
        logic         v, r;
        logic [W-1:0] o;
        int           lat;
        lat = s ? B + 1 : B;
        cur.prod = '0;
        cur.acc  = 0;
        forever begin
            @(negedge clk);
            #1;
            v = s ? is_if.outValid : iu_if.outValid;
            r = s ? is_if.outReady : iu_if.outReady;
            o = s ? is_if.out      : iu_if.out;
            if (rst) begin
                seen = 1'b0;
            end else if (v) begin
                if (!seen) begin
                    if (qsize(s) == 0) begin
                        check(s ? "spurious_s" : "spurious_u", 64'(1), 64'(0));
                    end else begin
                        cur = s ? q_s.pop_front() : q_u.pop_front();
                        check(s ? "prod_s" : "prod_u", 64'(o), 64'(cur.prod));
                        check(s ? "latency_s" : "latency_u", 64'(cyc - cur.acc), 64'(lat));
                    end
                    seen = 1'b1;
                end else begin
                    check(s ? "hold_s" : "hold_u", 64'(o), 64'(cur.prod));
                end
                if (r) seen = 1'b0;
            end else begin
                seen = 1'b0;
            end
        end
    endtask

    initial monitor(1'b0);
    initial monitor(1'b1);

    task automatic soak(input bit s);
        logic [A-1:0] av;
        logic [B-1:0] bv;
        for (int i = 0; i < SOAK_OPS; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            av = A'($urandom);
            bv = B'($urandom);
            if ($urandom_range(0, 15) == 0) bv = '0;
            send(s, av, bv);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    initial begin
        #1_500_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_run();
    end

    initial begin
        drive_in(1'b0, 1'b0, '0, '0);
        drive_in(1'b1, 1'b0, '0, '0);
        iu_if.outReady = 1'b1;
        is_if.outReady = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        check("rst_valid_u", 64'(iu_if.outValid), 64'(0));
        check("rst_out_u",   64'(iu_if.out),      64'(0));
        check("rst_valid_s", 64'(is_if.outValid), 64'(0));
        check("rst_out_s",   64'(is_if.out),      64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_u", 64'(iu_if.inReady), 64'(1));
        check("rst_ready_s", 64'(is_if.inReady), 64'(1));

        send_x(1'b0, 16'd3,    8'd5,  24'h00000F); wait_idle(1'b0);
        send_x(1'b0, 16'hFFFF, 8'hFF, 24'hFEFF01); wait_idle(1'b0);
        send_x(1'b0, 16'hFFFF, 8'h00, 24'h000000); wait_idle(1'b0);
        send_x(1'b1, 16'hFFFD, 8'd5,  24'hFFFFF1); wait_idle(1'b1);
        send_x(1'b1, 16'h8000, 8'h80, 24'h400000); wait_idle(1'b1);
        send_x(1'b1, 16'h8000, 8'h7F, 24'hC08000); wait_idle(1'b1);

        // Backpressure: product must hold while new operands are refused.
        is_if.outReady = 1'b0;
        send(1'b1, 16'h1234, 8'hF0);
        for (int n = 0; n < 50 && !is_if.outValid; n++) @(negedge clk);
        check("bp_valid", 64'(is_if.outValid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_in(1'b1, 1'b1, 16'h0101, 8'h02);
            #1;
            check("bp_inready", 64'(is_if.inReady), 64'(0));
            check("bp_valid_hold", 64'(is_if.outValid), 64'(1));
        end
        @(negedge clk);
        drive_in(1'b1, 1'b0, '0, '0);
        is_if.outReady = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(is_if.inReady), 64'(1));
        check("bp_release_valid", 64'(is_if.outValid), 64'(0));
        wait_idle(1'b1);

        // Reset mid-operation discards the pending product.
        send(1'b0, 16'h1111, 8'h22);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_valid", 64'(iu_if.outValid), 64'(0));
        check("midrst_out",   64'(iu_if.out),      64'(0));
        q_u.delete();
        @(negedge clk);
        rst = 1'b0;
        send_x(1'b0, 16'd7, 8'd6, 24'd42); wait_idle(1'b0);
        send_x(1'b1, 16'd7, 8'hFA, 24'hFFFFD6); wait_idle(1'b1);

        rnd_rdy = 1'b1;
        fork
            soak(1'b0);
            soak(1'b1);
        join
        rnd_rdy = 1'b0;
        @(negedge clk);
        iu_if.outReady = 1'b1;
        is_if.outReady = 1'b1;
        wait_idle(1'b0);
        wait_idle(1'b1);
        repeat (3) @(negedge clk);
        check("drain_u", 64'(q_u.size()), 64'(0));
        check("drain_s", 64'(q_s.size()), 64'(0));
        finish_run();
    end
endmodule
